mem_responder: RTL
==================

# mem_responder

Responder side of the core's store interface. Every cycle it samples `mem_addr`/`mem_data`/`mem_we` and decodes each write to one of three targets: a word-addressed data RAM, an LED output register, or a transmit byte FIFO that drains over a valid/ready stream to a serial transmitter. The core has no stall input, so the block accepts or drops every store in the same cycle it is issued. Errors are reported through sticky flags.

## Interface

Parameters:
- `RAM_WORDS`, 256: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: TX FIFO depth in bytes; power of two, ≥ 2.
- `LED_ADDR`, 32'h0000_0400: word address of the LED register.
- `TX_ADDR`, 32'h0000_0401: word address of the TX push port.

Ports:
- `clk` input, 1: the single clock; all state changes on its rising edge.
- `rst_n` input, 1: reset, synchronous and active-low.
- `mem_addr` input, 32: store word address from the core.
- `mem_data` input, 32: store data from the core.
- `mem_we` input, 1: store strobe; one store per cycle while high.
- `dbg_addr` input, `$clog2(RAM_WORDS)`: debug read address into the RAM.
- `dbg_rdata` output, 32: registered RAM read data.
- `led` output, 32: LED register.
- `tx_data` output, 8: FIFO head byte.
- `tx_valid` output, 1: FIFO not empty.
- `tx_ready` input, 1: downstream accepts `tx_data` this cycle.
- `store_cnt` output, 16: count of accepted (mapped) stores; saturates at 16'hFFFF.
- `ovf` output, 1: sticky; set when a TX push is dropped.
- `err` output, 1: sticky; set when a store targets an unmapped address.

## Operation

- Address decode applies only when `mem_we`=1.
  - `mem_addr < RAM_WORDS`: RAM write at `mem_addr[$clog2(RAM_WORDS)-1:0]`.
  - `mem_addr == LED_ADDR`: `led <= mem_data`.
  - `mem_addr == TX_ADDR`: push `mem_data[7:0]`; bits [31:8] are ignored.
  - Any other address: no state change except `err <= 1`.
- `store_cnt` increments on each RAM, LED or TX store, including a dropped TX push. It holds at 16'hFFFF once reached.
- The TX FIFO is first-word-fall-through.
  - `tx_data` always shows the head entry.
  - `tx_valid` = (level != 0).
  - A pop occurs when `tx_valid && tx_ready`.
  - `tx_data` is don't-care when `tx_valid`=0.
- Pushes and pops in the same cycle:
  - Push and pop together: level unchanged, and both take effect, including when the FIFO is full.
  - Push when full with no pop: byte dropped, `ovf <= 1`, FIFO unchanged.
  - `tx_ready` while empty: no effect.
- Pointers wrap modulo `FIFO_DEPTH`. The level counter is `$clog2(FIFO_DEPTH)+1` bits wide.
- `dbg_rdata <= ram[dbg_addr]` every cycle. A RAM read and write to the same address in the same cycle returns the old data (read-before-write).
- `ovf` and `err` clear only on reset.

## Timing

- Reset (`rst_n`=0 at a rising edge) sets:
  - `led`=0, `store_cnt`=0, `ovf`=0, `err`=0, `dbg_rdata`=0.
  - FIFO empty, so `tx_valid`=0.
  - RAM contents are not reset.
- Reset has priority over a store or pop in the same cycle. An in-flight FIFO is flushed.
- Store latency is 1 cycle: `led`, the FIFO level and the flags update at the edge that samples `mem_we`.
- A pushed byte appears on `tx_data`/`tx_valid` the cycle after the push edge when the FIFO was empty. There is no same-cycle bypass.
- `dbg_rdata` has 1-cycle read latency. RAM written at edge N is readable as `dbg_rdata` after edge N+1.
- `tx_data`/`tx_valid` are driven from registers or FIFO storage only, with no combinational path from `mem_*`. `tx_ready` may be combinational upstream.

## Structure

- Package `mem_map_pkg` holds:
  - default `LED_ADDR`/`TX_ADDR` constants;
  - the region-decode enum (`REG_RAM`, `REG_LED`, `REG_TX`, `REG_NONE`);
  - the data width (32) and TX byte width (8).
- Sub-module `tx_fifo`: parameterized FWFT FIFO with push/pop/full/empty/level, plus drop-on-full reporting.
- Top level contains the decoder, RAM array, LED register, counters and flags.

## Test plan

- Reset state: assert `rst_n`=0 for 2 cycles, then release. Expect `led`=0, `tx_valid`=0, `store_cnt`=0, `ovf`=0, `err`=0.
- RAM path: store 32'hDEADBEEF to address 5, then set `dbg_addr`=5. Expect `dbg_rdata`=32'hDEADBEEF after 1 cycle and `store_cnt`=1.
- Same-cycle RAM read/write: with `dbg_addr`=5, store 32'h1 to address 5 in the same cycle. Expect the old 32'hDEADBEEF first, then 32'h1 on the next cycle.
- LED and unmapped stores:
  - Store 32'h0000_00A5 to `LED_ADDR`: expect `led`=32'hA5.
  - Store to 32'h0000_0800: expect `err`=1, `led` unchanged, `store_cnt` unchanged.
- FIFO fill and overflow: hold `tx_ready`=0 and push bytes 1..9 to `TX_ADDR`. Expect:
  - `ovf`=1 after the 9th push;
  - then with `tx_ready`=1, bytes 1..8 drain in order;
  - `tx_valid`=0 afterwards.
- Full FIFO, simultaneous push and pop: fill to 8, then push 8'h55 with `tx_ready`=1. Expect level to stay at 8, `ovf` to stay 0, and 8'h55 to emerge last.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Purpose: shared memory-map constants, region enum and address decoder for mem_responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_map_pkg;

    localparam int DATA_W = 32;
    localparam int TX_W   = 8;

    localparam logic [DATA_W-1:0] LED_ADDR_DEF = 32'h0000_0400;
    localparam logic [DATA_W-1:0] TX_ADDR_DEF  = 32'h0000_0401;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_LED  = 2'd1,
        REG_TX   = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // The RAM window is checked first, so a peripheral address that falls
    // inside the RAM range is shadowed by the RAM.
    function automatic region_e decode_region(
        input logic [DATA_W-1:0] addr,
        input logic [DATA_W-1:0] ram_words,
        input logic [DATA_W-1:0] led_addr,
        input logic [DATA_W-1:0] tx_addr
    );
        region_e r;
        if (addr < ram_words) begin
            r = REG_RAM;
        end else if (addr == led_addr) begin
            r = REG_LED;
        end else if (addr == tx_addr) begin
            r = REG_TX;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Purpose: first-word-fall-through byte FIFO feeding the serial transmit stream.
// Latency: a push is visible on pop_dat/pop_vld one cycle after the push edge; no bypass.
// Backpressure: pop on pop_vld && pop_rdy; push is never stalled, it is dropped when full
//               without a simultaneous pop and reported on push_drop.
// Ports: clk, rst_n (sync, active-low); push_vld/push_dat in; pop_dat/pop_vld out,
//        pop_rdy in; full/empty/level status; push_drop pulses on a dropped push.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    output logic [W-1:0]               pop_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       push_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q,  level_d;

    logic pop_fire;
    logic push_fire;

    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LW'(DEPTH));
        pop_vld   = !empty;
        pop_dat   = mem_q[rd_ptr_q];
        level     = level_q;
        pop_fire  = pop_vld && pop_rdy;
        // When full, a concurrent pop frees the head slot, which is exactly
        // the slot wr_ptr points at, so the push can land there this edge.
        push_fire = push_vld && (!full || pop_fire);
        push_drop = push_vld && full && !pop_fire;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push_fire) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Purpose: store-side responder decoding core writes to data RAM, LED register or TX FIFO.
// Latency: stores take effect at the sampling edge; dbg_rdata is a 1-cycle registered read.
// Backpressure: none toward the core (stores accepted or dropped same cycle); TX side
//               is valid/ready, pushes to a full FIFO are dropped and flagged on ovf.
// Ports: clk, rst_n (sync, active-low); mem_addr/mem_data/mem_we store port;
//        dbg_addr/dbg_rdata debug read; led; tx_data/tx_valid/tx_ready stream;
//        store_cnt (saturating), ovf and err sticky flags.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int                RAM_WORDS  = 256,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] LED_ADDR   = LED_ADDR_DEF,
    parameter logic [DATA_W-1:0] TX_ADDR    = TX_ADDR_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_data,
    input  logic                          mem_we,
    input  logic [$clog2(RAM_WORDS)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]             dbg_rdata,
    output logic [DATA_W-1:0]             led,
    output logic [TX_W-1:0]               tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [15:0]                   store_cnt,
    output logic                          ovf,
    output logic                          err
);

    localparam int AW = $clog2(RAM_WORDS);

    region_e region;
    logic    ram_we;
    logic    led_we;
    logic    tx_push;
    logic    unmapped;
    logic    mapped;

    logic [DATA_W-1:0] ram_mem [RAM_WORDS];

    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [DATA_W-1:0] led_q,       led_d;
    logic [15:0]       store_cnt_q, store_cnt_d;
    logic              ovf_q,       ovf_d;
    logic              err_q,       err_d;

    logic                        fifo_drop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    // ---------------- decode ----------------
    always_comb begin
        region   = decode_region(mem_addr, DATA_W'(RAM_WORDS), LED_ADDR, TX_ADDR);
        ram_we   = 1'b0;
        led_we   = 1'b0;
        tx_push  = 1'b0;
        unmapped = 1'b0;
        if (mem_we) begin
            case (region)
                REG_RAM:  ram_we   = 1'b1;
                REG_LED:  led_we   = 1'b1;
                REG_TX:   tx_push  = 1'b1;
                default:  unmapped = 1'b1;
            endcase
        end
        // A dropped TX push still counts as an accepted store.
        mapped = ram_we || led_we || tx_push;
    end

    // ---------------- data RAM ----------------
    // Reset has priority over a store, so the write is suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            ram_mem[mem_addr[AW-1:0]] <= mem_data;
        end
    end

    // ---------------- registers ----------------
    always_comb begin
        // Array read sees pre-edge contents: read-before-write on a collision.
        dbg_rdata_d = ram_mem[dbg_addr];
        led_d       = led_we ? mem_data : led_q;
        store_cnt_d = store_cnt_q;
        if (mapped && (store_cnt_q != 16'hFFFF)) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
        ovf_d = ovf_q | fifo_drop;
        err_d = err_q | unmapped;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_rdata_q <= '0;
            led_q       <= '0;
            store_cnt_q <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dbg_rdata_q <= dbg_rdata_d;
            led_q       <= led_d;
            store_cnt_q <= store_cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    // ---------------- TX FIFO ----------------
    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TX_W)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (tx_push),
        .push_dat  (mem_data[TX_W-1:0]),
        .pop_dat   (tx_data),
        .pop_vld   (tx_valid),
        .pop_rdy   (tx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .push_drop (fifo_drop)
    );

    // Upper store-data bits are meaningless for TX pushes; FIFO status is
    // informational here since tx_valid already carries "not empty".
    logic unused_bits;
    assign unused_bits = ^{fifo_full, fifo_empty, fifo_level, mem_data[DATA_W-1:TX_W]};

    assign dbg_rdata = dbg_rdata_q;
    assign led       = led_q;
    assign store_cnt = store_cnt_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule
